alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Command-driven initiator/sequencer for the existing combinational `alu` block.
- Accepts ALU commands over a valid/ready handshake, registers the operands, and drives the ALU.
- Can iterate one op N times on a working register, e.g. repeated add for multiply-by-constant.
- Returns result plus flags over a second valid/ready handshake; maintains an accumulator and a sticky status register for the datapath controller.

Parameters:
- NBIT, 4: operand/result width; passed to the `alu` nbit parameter.
- REPW, 3: width of the repeat-count field.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  3  ALU select code, same encoding as `alu` sel.
- cmd_src  input  1  1: first A operand = accumulator; 0: first A operand = cmd_a.
- cmd_a  input  NBIT  A operand, signed.
- cmd_b  input  NBIT  B operand, signed; held for all iterations.
- cmd_rep  input  REPW  extra iterations; op is executed cmd_rep+1 times.
- cmd_wb  input  1  1: write final result to accumulator.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_result  output  NBIT  final result.
- rsp_flags  output  3  {overflow, zero, carry}.
- acc  output  NBIT  accumulator value.
- sticky_ovf  output  1  overflow seen since last clear.
- clr_sticky  input  1  synchronous clear of sticky_ovf.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - acc, rsp_result, rsp_flags, rsp_valid, sticky_ovf, internal registers all 0.
  - cmd_ready=1 during reset and in IDLE.
  - Reset mid-command drops the command; no response is produced.
- FSM states IDLE, EXEC, RESP.
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready:
    - latch op, b, wb.
    - work <= cmd_src ? acc : cmd_a.
    - cnt <= cmd_rep.
    - clear the flag OR-registers; go to EXEC.
  - EXEC: ALU inputs are A=work, B=b_reg, sel=op_reg.
    - Each cycle: work <= alu result; ovf_acc |= overflow; cy_acc |= carry.
    - If cnt==0: capture rsp_result = alu result, rsp_flags = {ovf_acc|overflow, result==0, cy_acc|carry}; if wb_reg, acc <= result; go to RESP.
    - Else: cnt <= cnt-1 and stay in EXEC.
  - RESP: rsp_valid=1; rsp_result and rsp_flags held stable until handshake.
    - On rsp_ready, go to IDLE (cmd_ready=1 the next cycle).
- Latency:
  - Command accepted at cycle T: rsp_valid is high from T+2+cmd_rep.
  - Peak throughput is one command per cmd_rep+3 cycles.
  - cmd_ready=0 in EXEC and RESP; there is no overlap.
- Arithmetic and flags:
  - Flags come from `alu`: signed compare for op 110; carry is bit NBIT of the (NBIT+1)-bit sum/difference.
  - Ops 010..111 give overflow=carry=0.
  - Zero reflects the final result only.
- sticky_ovf:
  - Set on the cycle the response is captured, if rsp_flags overflow=1.
  - clr_sticky clears it.
  - If set and clear occur in the same cycle, set wins.
- cmd_src=1 with cmd_wb=0: acc is read but not modified.

Decomposition:
- Shared package holds:
  - ALU op localparams: OP_ADD=000, OP_SUB=001, OP_NOT=010, OP_AND=011, OP_OR=100, OP_XOR=101, OP_LT=110, OP_EQ=111.
  - FSM state encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
  - Flag bit indices: OVF=2, ZERO=1, CARRY=0.
- One sub-module: the existing `alu` instantiated with nbit=NBIT. All other logic stays in alu_seq.

Test Plan (NBIT=4, REPW=3):
- Simple add: cmd add, a=3, b=4, src=0, rep=0, wb=1, accepted at T -> rsp_valid at T+2, result=7, flags=000, acc=7, sticky_ovf=0.
- Signed overflow: add a=7, b=1 -> result=4'h8, flags=100, sticky_ovf=1. Then clr_sticky=1 for one cycle -> sticky_ovf=0. Also cover set and clear in the same cycle -> sticky_ovf=1.
- Repeat add: acc=3 preloaded; add src=1, b=3, rep=2 -> rsp_valid at T+4, result=4'hC, flags=100 (6+3 overflows), acc=4'hC.
- Zero and compare:
  - sub a=5, b=5 -> result=0, flags=010.
  - op 110, a=4'hF (-1), b=1 -> result=1, flags=000.
  - op 111, a=2, b=3 -> result=0, flags=010.
- Backpressure: hold rsp_ready=0 for 3 cycles after rsp_valid -> rsp_valid, result and flags stable, cmd_ready=0, new cmd_valid ignored. Then rsp_ready=1 -> cmd_ready=1 next cycle.
- Reset mid-command: rep=5, drop rst_n during the 2nd EXEC cycle -> all outputs 0 asynchronously, acc=0, no response after release, cmd_ready=1 and the next command completes normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared ALU op codes, sequencer state encoding and flag indices
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int FLAG_OVF   = 2;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_CARRY = 0;

endpackage

`default_nettype wire

// File: rtl/alu_seq_if.sv
// ============================================================================
//  Module      : alu_seq_if
//  Description : Command/response handshakes and status bundle of alu_seq
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_seq_if #(
    parameter int NBIT = 4,
    parameter int REPW = 3
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      cmd_op;
    logic            cmd_src;
    logic [NBIT-1:0] cmd_a;
    logic [NBIT-1:0] cmd_b;
    logic [REPW-1:0] cmd_rep;
    logic            cmd_wb;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [NBIT-1:0] rsp_result;
    logic [2:0]      rsp_flags;
    logic [NBIT-1:0] acc;
    logic            sticky_ovf;
    logic            clr_sticky;

    // slave: the sequencer side
    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_a, cmd_b, cmd_rep, cmd_wb,
        input  rsp_ready, clr_sticky,
        output cmd_ready, rsp_valid, rsp_result, rsp_flags, acc, sticky_ovf
    );

    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_a, cmd_b, cmd_rep, cmd_wb,
        output rsp_ready, clr_sticky,
        input  cmd_ready, rsp_valid, rsp_result, rsp_flags, acc, sticky_ovf
    );

endinterface

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
//  Module      : alu
//  Description : Combinational signed ALU with overflow/zero/carry flags
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu
    import alu_seq_pkg::*;
#(
    parameter int nbit = 4
) (
    input  wire logic [nbit-1:0] i_a,
    input  wire logic [nbit-1:0] i_b,
    input  wire logic [2:0]      i_sel,
    output logic      [nbit-1:0] o_result,
    output logic                 o_overflow,
    output logic                 o_zero,
    output logic                 o_carry
);

    localparam int c_MSB = nbit - 1;

    logic [nbit:0] w_sum;
    logic [nbit:0] w_diff;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    // carry out of the subtraction is the borrow bit
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_result   = '0;
        o_overflow = 1'b0;
        o_carry    = 1'b0;
        case (i_sel)
            OP_ADD: begin
                o_result   = w_sum[nbit-1:0];
                o_carry    = w_sum[nbit];
                o_overflow = (i_a[c_MSB] == i_b[c_MSB]) && (w_sum[c_MSB] != i_a[c_MSB]);
            end
            OP_SUB: begin
                o_result   = w_diff[nbit-1:0];
                o_carry    = w_diff[nbit];
                o_overflow = (i_a[c_MSB] != i_b[c_MSB]) && (w_diff[c_MSB] != i_a[c_MSB]);
            end
            OP_NOT:  o_result = ~i_a;
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_LT:   o_result = {{(nbit-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            OP_EQ:   o_result = {{(nbit-1){1'b0}}, (i_a == i_b)};
            default: o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
//  Module      : alu_seq
//  Description : Command sequencer around alu: iterates an op on a working
//                register, returns result/flags, keeps accumulator and sticky ovf
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int NBIT = 4,
    parameter int REPW = 3
) (
    input  wire logic clk,
    input  wire logic rst_n,
    alu_seq_if.slave  bus
);

    state_t          r_state;
    state_t          w_next;
    logic [2:0]      r_op;
    logic [NBIT-1:0] r_b;
    logic            r_wb;
    logic [NBIT-1:0] r_work;
    logic [REPW-1:0] r_cnt;
    logic            r_ovf_acc;
    logic            r_cy_acc;
    logic [NBIT-1:0] r_acc;
    logic [NBIT-1:0] r_result;
    logic [2:0]      r_flags;
    logic            r_sticky;

    logic            w_cmd_ready;
    logic            w_rsp_valid;
    logic            w_accept;
    logic            w_capture;
    logic [NBIT-1:0] w_alu_res;
    logic            w_alu_ovf;
    logic            w_alu_zero;
    logic            w_alu_cy;
    logic [2:0]      w_flags;

    alu #(
        .nbit (NBIT)
    ) u_alu (
        .i_a        (r_work),
        .i_b        (r_b),
        .i_sel      (r_op),
        .o_result   (w_alu_res),
        .o_overflow (w_alu_ovf),
        .o_zero     (w_alu_zero),
        .o_carry    (w_alu_cy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cmd_ready = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) w_next = EXEC;
            end
            EXEC: begin
                if (r_cnt == '0) w_next = RESP;
            end
            RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_accept  = (r_state == IDLE) && bus.cmd_valid;
    assign w_capture = (r_state == EXEC) && (r_cnt == '0);

    // overflow/carry accumulate across iterations, zero is the final result only
    always_comb begin
        w_flags             = '0;
        w_flags[FLAG_OVF]   = r_ovf_acc | w_alu_ovf;
        w_flags[FLAG_ZERO]  = w_alu_zero;
        w_flags[FLAG_CARRY] = r_cy_acc | w_alu_cy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= '0;
            r_b       <= '0;
            r_wb      <= 1'b0;
            r_work    <= '0;
            r_cnt     <= '0;
            r_ovf_acc <= 1'b0;
            r_cy_acc  <= 1'b0;
            r_acc     <= '0;
            r_result  <= '0;
            r_flags   <= '0;
        end else if (w_accept) begin
            r_op      <= bus.cmd_op;
            r_b       <= bus.cmd_b;
            r_wb      <= bus.cmd_wb;
            r_work    <= bus.cmd_src ? r_acc : bus.cmd_a;
            r_cnt     <= bus.cmd_rep;
            r_ovf_acc <= 1'b0;
            r_cy_acc  <= 1'b0;
        end else if (r_state == EXEC) begin
            r_work    <= w_alu_res;
            r_ovf_acc <= r_ovf_acc | w_alu_ovf;
            r_cy_acc  <= r_cy_acc | w_alu_cy;
            if (w_capture) begin
                r_result <= w_alu_res;
                r_flags  <= w_flags;
                if (r_wb) r_acc <= w_alu_res;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // a capture with overflow beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
        end else if (w_capture && w_flags[FLAG_OVF]) begin
            r_sticky <= 1'b1;
        end else if (bus.clr_sticky) begin
            r_sticky <= 1'b0;
        end
    end

    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.rsp_result = r_result;
    assign bus.rsp_flags  = r_flags;
    assign bus.acc        = r_acc;
    assign bus.sticky_ovf = r_sticky;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Directed self-checking bench for alu_seq (NBIT=4, REPW=3)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;
    import alu_seq_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   n_fail;
    int   lat;
    int   seen;

    alu_seq_if #(.NBIT(4), .REPW(3)) bus ();

    alu_seq #(.NBIT(4), .REPW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command from IDLE; returns cycles from the accepting edge to rsp_valid
    task automatic do_cmd(input logic [2:0] op, input logic src, input logic [3:0] a,
                          input logic [3:0] b, input logic [2:0] rep, input logic wb,
                          output int cycles);
        bus.cmd_op    = op;
        bus.cmd_src   = src;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_rep   = rep;
        bus.cmd_wb    = wb;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        cycles = 0;
        while (!bus.rsp_valid && cycles < 30) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; n_fail = 0;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_src = 1'b0; bus.cmd_a = '0;
        bus.cmd_b = '0; bus.cmd_rep = '0; bus.cmd_wb = 1'b0;
        bus.rsp_ready = 1'b1; bus.clr_sticky = 1'b0;
        #1;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_acc",       32'(bus.acc), 32'd0);
        check("rst_result",    32'(bus.rsp_result), 32'd0);
        check("rst_flags",     32'(bus.rsp_flags), 32'd0);
        check("rst_sticky",    32'(bus.sticky_ovf), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        step();

        // simple add 3+4
        do_cmd(OP_ADD, 1'b0, 4'd3, 4'd4, 3'd0, 1'b1, lat);
        check("add_lat",    32'(lat), 32'd1);
        check("add_result", 32'(bus.rsp_result), 32'h7);
        check("add_flags",  32'(bus.rsp_flags), 32'b000);
        check("add_acc",    32'(bus.acc), 32'h7);
        check("add_sticky", 32'(bus.sticky_ovf), 32'd0);
        check("add_cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
        step();

        // signed overflow 7+1, no writeback
        do_cmd(OP_ADD, 1'b0, 4'd7, 4'd1, 3'd0, 1'b0, lat);
        check("ovf_result", 32'(bus.rsp_result), 32'h8);
        check("ovf_flags",  32'(bus.rsp_flags), 32'b100);
        check("ovf_sticky", 32'(bus.sticky_ovf), 32'd1);
        check("ovf_acc_kept", 32'(bus.acc), 32'h7);
        step();
        bus.clr_sticky = 1'b1;
        step();
        bus.clr_sticky = 1'b0;
        check("clr_sticky", 32'(bus.sticky_ovf), 32'd0);

        // set and clear on the same edge: set wins
        bus.clr_sticky = 1'b1;
        do_cmd(OP_ADD, 1'b0, 4'd7, 4'd1, 3'd0, 1'b0, lat);
        check("set_wins_sticky", 32'(bus.sticky_ovf), 32'd1);
        step();
        check("clr_after_set", 32'(bus.sticky_ovf), 32'd0);
        bus.clr_sticky = 1'b0;

        // preload acc=3 then repeated add from acc
        do_cmd(OP_ADD, 1'b0, 4'd0, 4'd3, 3'd0, 1'b1, lat);
        check("preload_acc", 32'(bus.acc), 32'h3);
        step();
        do_cmd(OP_ADD, 1'b1, 4'd9, 4'd3, 3'd2, 1'b1, lat);
        check("rep_lat",    32'(lat), 32'd3);
        check("rep_result", 32'(bus.rsp_result), 32'hC);
        check("rep_flags",  32'(bus.rsp_flags), 32'b100);
        check("rep_acc",    32'(bus.acc), 32'hC);
        step();
        bus.clr_sticky = 1'b1;
        step();
        bus.clr_sticky = 1'b0;

        // zero and compares
        do_cmd(OP_SUB, 1'b0, 4'd5, 4'd5, 3'd0, 1'b0, lat);
        check("sub_result", 32'(bus.rsp_result), 32'h0);
        check("sub_flags",  32'(bus.rsp_flags), 32'b010);
        check("sub_acc_kept", 32'(bus.acc), 32'hC);
        step();
        do_cmd(OP_LT, 1'b0, 4'hF, 4'd1, 3'd0, 1'b0, lat);
        check("lt_result", 32'(bus.rsp_result), 32'h1);
        check("lt_flags",  32'(bus.rsp_flags), 32'b000);
        step();
        do_cmd(OP_EQ, 1'b0, 4'd2, 4'd3, 3'd0, 1'b0, lat);
        check("eq_result", 32'(bus.rsp_result), 32'h0);
        check("eq_flags",  32'(bus.rsp_flags), 32'b010);
        step();

        // backpressure with a competing command held on the bus
        bus.rsp_ready = 1'b0;
        do_cmd(OP_XOR, 1'b0, 4'd5, 4'd3, 3'd0, 1'b1, lat);
        check("bp_lat",    32'(lat), 32'd1);
        check("bp_result", 32'(bus.rsp_result), 32'h6);
        check("bp_acc",    32'(bus.acc), 32'h6);
        bus.cmd_op = OP_ADD; bus.cmd_src = 1'b0; bus.cmd_a = 4'd1; bus.cmd_b = 4'd1;
        bus.cmd_rep = 3'd0; bus.cmd_wb = 1'b1; bus.cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_valid_hold",  32'(bus.rsp_valid), 32'd1);
            check("bp_result_hold", 32'(bus.rsp_result), 32'h6);
            check("bp_flags_hold",  32'(bus.rsp_flags), 32'b000);
            check("bp_cmd_ready",   32'(bus.cmd_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        check("bp_release_ready", 32'(bus.cmd_ready), 32'd1);
        check("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
        step();
        check("bp_ignored_cmd_acc", 32'(bus.acc), 32'h6);

        // reset during the second EXEC cycle of a long command
        bus.cmd_op = OP_ADD; bus.cmd_src = 1'b0; bus.cmd_a = 4'd1; bus.cmd_b = 4'd1;
        bus.cmd_rep = 3'd5; bus.cmd_wb = 1'b1; bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid",  32'(bus.rsp_valid), 32'd0);
        check("mid_rst_ready",  32'(bus.cmd_ready), 32'd1);
        check("mid_rst_acc",    32'(bus.acc), 32'd0);
        check("mid_rst_result", 32'(bus.rsp_result), 32'd0);
        check("mid_rst_flags",  32'(bus.rsp_flags), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.rsp_valid) seen++;
        end
        check("mid_rst_no_rsp", 32'(seen), 32'd0);
        check("mid_rst_idle_ready", 32'(bus.cmd_ready), 32'd1);
        do_cmd(OP_ADD, 1'b0, 4'd2, 4'd3, 3'd1, 1'b1, lat);
        check("post_rst_lat",    32'(lat), 32'd2);
        check("post_rst_result", 32'(bus.rsp_result), 32'h8);
        check("post_rst_flags",  32'(bus.rsp_flags), 32'b100);
        check("post_rst_acc",    32'(bus.acc), 32'h8);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
